clock_display_driver: RTL

//  Downstream display stage of the time counter. Samples binary hours/minutes/seconds.

---
 rtl/clock_display_driver_if.sv | 12 +
 rtl/clock_display_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clock_display_driver_if.sv
// Time-field handshake between the time counter and the display driver.
// The master drives the binary time fields and update; the slave answers with ready.
interface clock_display_driver_if;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       update;
    logic       ready;

    modport master (output hours, minutes, seconds, update, input ready);
    modport slave  (input hours, minutes, seconds, update, output ready);
endinterface

// File: rtl/clock_display_driver.sv
// HH.MM.SS seven-segment driver: samples binary time, converts it to BCD with double-dabble, scans 6 digits.
// Optional macro DP_SEPARATOR_EN lights the decimal points that separate the HH, MM and SS fields.
module clock_display_dd_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture,
    input  logic       step,
    input  logic [7:0] bin,
    output logic [7:0] bcd
);
    logic [6:0] sh;
    logic [7:0] adj;

    function automatic logic [6:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 7'd99 : v[6:0];
    endfunction

    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            sh  <= '0;
        end else if (capture) begin
            bcd <= '0;
            sh  <= sat99(bin);
        end else if (step) begin
            // The tens nibble never exceeds 9 for inputs <=99, so the lost top bit is always 0.
            {bcd, sh} <= {adj, sh} << 1;
        end
    end
endmodule

module clock_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    clock_display_driver_if.slave bus,
    output logic [7:0]            AN,
    output logic [6:0]            SEG,
    output logic                  DP
);
    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 8;
    localparam int CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t state, state_nxt;
    logic [2:0] iter;
    logic capture, step;

    // Lane 0 = seconds, 1 = minutes, 2 = hours; this makes the packed BCD match the digit index order.
    logic [NUM_LANES-1:0][VEC_W-1:0] field_bin, field_bcd;
    assign field_bin = {bus.hours, bus.minutes, bus.seconds};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            clock_display_dd_lane u_lane (
                .clk     (CLK100MHZ),
                .rst_n   (reset),
                .capture (capture),
                .step    (step),
                .bin     (field_bin[i]),
                .bcd     (field_bcd[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            iter  <= step ? iter + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        bus.ready = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.update) begin
                    capture   = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                step = 1'b1;
                if (iter == 3'd6) state_nxt = LOAD;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [5:0][3:0] disp;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset)             disp <= '0;
        else if (state == LOAD) disp <= field_bcd;
    end

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          wrap;
    assign wrap = (cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    logic [3:0] nib;

    always_comb begin
        nib = 4'd0;
        case (idx)
            3'd0: nib = disp[0];
            3'd1: nib = disp[1];
            3'd2: nib = disp[2];
            3'd3: nib = disp[3];
            3'd4: nib = disp[4];
            3'd5: nib = disp[5];
            default: nib = 4'd0;
        endcase
    end

    always_comb begin
        AN = ~(8'd1 << idx);
        case (nib)
            4'd0: SEG = 7'b1000000;
            4'd1: SEG = 7'b1111001;
            4'd2: SEG = 7'b0100100;
            4'd3: SEG = 7'b0110000;
            4'd4: SEG = 7'b0011001;
            4'd5: SEG = 7'b0010010;
            4'd6: SEG = 7'b0000010;
            4'd7: SEG = 7'b1111000;
            4'd8: SEG = 7'b0000000;
            4'd9: SEG = 7'b0010000;
            default: SEG = 7'b1111111;
        endcase
    end

`ifdef DP_SEPARATOR_EN
    assign DP = ~((idx == 3'd2) || (idx == 3'd4));
`else
    assign DP = 1'b1;
`endif
endmodule
